// File: rtl/vcve2_fracturable_redsum.sv
// ---------------------------------------------------------------------------
// vcve2_fracturable_redsum
//
// Sequential vector sum-reduction unit (vredsum semantics). Each reduction
// adds every SEW-wide element of a stream of PIPE_WIDTH-bit vs2 words into a
// lane accumulator. It then folds the accumulator in half until a single lane
// is left, and adds the vs1[0] scalar to that lane. Every addition is
// fracturable: the carry is cut at each SEW boundary, so each lane wraps
// modulo 2^SEW.
//
// Flow: IDLE -> ACCUM (one cycle per accepted word) -> FOLD (F cycles,
// F = log2(PIPE_WIDTH/SEW)) -> FINAL (1 cycle) -> DONE (hold until taken).
// PIPE_WIDTH must be a power-of-two multiple of 32 so that the fold halves
// evenly down to one lane.
//
// Parameters:
//   PIPE_WIDTH  datapath width in bits
//   MAX_WORDS   maximum vs2 words per reduction (larger requests are clamped)
//   CNT_W       width of the word counter (derived)
//
// Ports:
//   clk_i           clock
//   rst_i           synchronous reset, active-high
//   start_i         begin a reduction (only honoured in IDLE)
//   sew_i           element width: 00=8, 01=16, 1x=32 (latched at start)
//   num_words_i     vs2 words to consume, 0..MAX_WORDS (latched at start)
//   scalar_i        vs1[0]; only the low SEW bits are used (latched at start)
//   busy_o          high in every state except IDLE
//   word_valid_i    vs2 word valid
//   word_ready_o    word accepted this cycle when valid (ACCUM only)
//   word_i          packed vs2 elements
//   result_valid_o  result available (DONE)
//   result_ready_i  consumer takes the result
//   result_o        reduced element, zero-extended above SEW
//   ovf_o           (only with VCVE2_REDSUM_OVF_EN) sticky flag: some lane
//                   add in this reduction carried out of the SEW bits
//
// Optional feature macro: VCVE2_REDSUM_OVF_EN (adds ovf_o and carry detect).
// ---------------------------------------------------------------------------
module vcve2_fracturable_redsum #(
    parameter int PIPE_WIDTH = 32,
    parameter int MAX_WORDS  = 16,
    parameter int CNT_W      = $clog2(MAX_WORDS + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [1:0]            sew_i,
    input  logic [CNT_W-1:0]      num_words_i,
    input  logic [31:0]           scalar_i,
    output logic                  busy_o,
    input  logic                  word_valid_i,
    output logic                  word_ready_o,
    input  logic [PIPE_WIDTH-1:0] word_i,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
`ifdef VCVE2_REDSUM_OVF_EN
    output logic                  ovf_o,
`endif
    output logic [31:0]           result_o
);

    localparam int NBYTES    = PIPE_WIDTH / 8;
    localparam int LOG_BYTES = $clog2(NBYTES);
    localparam int IDX_W     = $clog2(LOG_BYTES + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ACCUM = 3'd1;
    localparam logic [2:0] S_FOLD  = 3'd2;
    localparam logic [2:0] S_FINAL = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]            state_q;
    logic [1:0]            sew_q;
    logic [CNT_W-1:0]      num_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [31:0]           scalar_q;
    logic [PIPE_WIDTH-1:0] acc_q;
    logic [IDX_W-1:0]      fold_q;
    logic [31:0]           result_q;
`ifdef VCVE2_REDSUM_OVF_EN
    logic                  ovf_q;
    logic                  carry_any;
`endif

    logic [CNT_W-1:0]      num_clamped;
    logic [1:0]            sew_log;      // log2(SEW/8)
    logic [IDX_W-1:0]      fold_total;   // F for the latched SEW
    logic [31:0]           sew_mask;
    int                    lane_bytes;
    int                    fold_half;    // bit width of the lower half being folded onto
    logic [PIPE_WIDTH-1:0] lo_mask;
    logic [PIPE_WIDTH-1:0] op_a;
    logic [PIPE_WIDTH-1:0] op_b;
    logic [PIPE_WIDTH-1:0] sum;
    logic [8:0]            byte_sum;
    logic                  carry;

    assign busy_o         = (state_q != S_IDLE);
    assign word_ready_o   = (state_q == S_ACCUM);
    assign result_valid_o = (state_q == S_DONE);
    assign result_o       = result_q;
`ifdef VCVE2_REDSUM_OVF_EN
    assign ovf_o          = ovf_q;
`endif

    assign num_clamped = (num_words_i > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : num_words_i;
    assign sew_log     = sew_q[1] ? 2'd2 : {1'b0, sew_q[0]};
    assign fold_total  = IDX_W'(LOG_BYTES) - IDX_W'(sew_log);
    assign sew_mask    = sew_q[1] ? 32'hFFFF_FFFF : (sew_q[0] ? 32'h0000_FFFF : 32'h0000_00FF);

    // Operand selection for the single shared fracturable adder. In FOLD,
    // both halves are masked to the lower half so lanes above the active
    // region add 0+0 and can never raise a spurious carry.
    // NOTE: every signal written in an always_comb gets a default at the top;
    // a path that skips an assignment would otherwise infer a latch.
    always_comb begin
        fold_half = PIPE_WIDTH >> (32'(fold_q) + 32'd1);
        lo_mask   = ~({PIPE_WIDTH{1'b1}} << fold_half);
        op_a      = '0;
        op_b      = '0;
        case (state_q)
            S_ACCUM: begin
                op_a = acc_q;
                op_b = word_i;
            end
            S_FOLD: begin
                op_a = acc_q & lo_mask;
                op_b = (acc_q >> fold_half) & lo_mask;
            end
            S_FINAL: begin
                op_a = PIPE_WIDTH'(acc_q[31:0] & sew_mask);
                op_b = PIPE_WIDTH'(scalar_q & sew_mask);
            end
            default: ;
        endcase
    end

    // Byte-sliced ripple adder; the carry into a byte is forced to 0 where a
    // new SEW lane begins, and the carry out of a lane's top byte is the lane
    // overflow.
    always_comb begin
        lane_bytes = 1 << sew_log;
        sum        = '0;
        byte_sum   = '0;
        carry      = 1'b0;
`ifdef VCVE2_REDSUM_OVF_EN
        carry_any  = 1'b0;
`endif
        for (int b = 0; b < NBYTES; b++) begin
            if ((b % lane_bytes) == 0) begin
                carry = 1'b0;
            end
            byte_sum       = {1'b0, op_a[b*8 +: 8]} + {1'b0, op_b[b*8 +: 8]} + {8'd0, carry};
            sum[b*8 +: 8]  = byte_sum[7:0];
            carry          = byte_sum[8];
`ifdef VCVE2_REDSUM_OVF_EN
            if (((b + 1) % lane_bytes) == 0) begin
                carry_any = carry_any | carry;
            end
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            sew_q    <= '0;
            num_q    <= '0;
            cnt_q    <= '0;
            scalar_q <= '0;
            acc_q    <= '0;
            fold_q   <= '0;
            result_q <= '0;
`ifdef VCVE2_REDSUM_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        sew_q    <= sew_i;
                        num_q    <= num_clamped;
                        scalar_q <= scalar_i;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        fold_q   <= '0;
`ifdef VCVE2_REDSUM_OVF_EN
                        ovf_q    <= 1'b0;
`endif
                        state_q  <= (num_clamped != '0) ? S_ACCUM : S_FINAL;
                    end
                end
                S_ACCUM: begin
                    if (word_valid_i) begin
                        acc_q <= sum;
                        cnt_q <= cnt_q + CNT_W'(1);
`ifdef VCVE2_REDSUM_OVF_EN
                        ovf_q <= ovf_q | carry_any;
`endif
                        if (cnt_q + CNT_W'(1) == num_q) begin
                            state_q <= (fold_total == '0) ? S_FINAL : S_FOLD;
                        end
                    end
                end
                S_FOLD: begin
                    acc_q  <= sum;
                    fold_q <= fold_q + IDX_W'(1);
`ifdef VCVE2_REDSUM_OVF_EN
                    ovf_q  <= ovf_q | carry_any;
`endif
                    if (fold_q + IDX_W'(1) == fold_total) begin
                        state_q <= S_FINAL;
                    end
                end
                S_FINAL: begin
                    result_q <= sum[31:0];
`ifdef VCVE2_REDSUM_OVF_EN
                    ovf_q    <= ovf_q | carry_any;
`endif
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    if (result_ready_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vcve2_fracturable_redsum.sv
// ---------------------------------------------------------------------------
// Self-checking bench for vcve2_fracturable_redsum.
// A transaction-level model (element arrays, modular arithmetic and a
// latency countdown) predicts busy/ready/valid/result every cycle, and a
// compare process checks the DUT against it on each falling edge. Directed
// cases pin the model with hand-computed literals. Randomized reductions
// follow. Build with +define+VCVE2_REDSUM_OVF_EN to also check ovf_o.
// ---------------------------------------------------------------------------
module tb_vcve2_fracturable_redsum;

    localparam int PW   = 32;
    localparam int MAXW = 16;
    localparam int CW   = $clog2(MAXW + 1);

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [1:0]    sew_i;
    logic [CW-1:0] num_words_i;
    logic [31:0]   scalar_i;
    logic          busy_o;
    logic          word_valid_i;
    logic          word_ready_o;
    logic [PW-1:0] word_i;
    logic          result_valid_o;
    logic          result_ready_i;
    logic [31:0]   result_o;
`ifdef VCVE2_REDSUM_OVF_EN
    logic          ovf_o;
`endif

    vcve2_fracturable_redsum #(.PIPE_WIDTH(PW), .MAX_WORDS(MAXW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .sew_i          (sew_i),
        .num_words_i    (num_words_i),
        .scalar_i       (scalar_i),
        .busy_o         (busy_o),
        .word_valid_i   (word_valid_i),
        .word_ready_o   (word_ready_o),
        .word_i         (word_i),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
`ifdef VCVE2_REDSUM_OVF_EN
        .ovf_o          (ovf_o),
`endif
        .result_o       (result_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit cmp_en = 1'b0;
    bit rdy_seen = 1'b0;
    logic [PW-1:0] wbuf [MAXW];

    always @(posedge clk_i) cyc <= cyc + 1;
    always @(negedge clk_i) if (word_ready_o === 1'b1) rdy_seen = 1'b1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail_timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    function automatic int sew_bits(input logic [1:0] s);
        return s[1] ? 32 : (s[0] ? 16 : 8);
    endfunction

    function automatic int fold_count(input int sew);
        int n = PW / sew;
        int f = 0;
        while (n > 1) begin
            n = n / 2;
            f++;
        end
        return f;
    endfunction

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 taking words, 2 counting down fold+final, 3 result held
    int                m_phase = 0;
    int                m_sew, m_n, m_cnt, m_wait;
    logic [31:0]       m_scalar;
    logic [31:0]       m_res = '0;
    bit                m_ovf = 1'b0;
    longint unsigned   m_lanes [PW/8];

    always @(posedge clk_i) begin
        longint unsigned mask, s;
        int n, h;
        if (rst_i) begin
            m_phase = 0;
            m_res   = '0;
            m_ovf   = 1'b0;
        end else begin
            case (m_phase)
                0: if (start_i) begin
                    m_sew    = sew_bits(sew_i);
                    m_n      = (int'(num_words_i) > MAXW) ? MAXW : int'(num_words_i);
                    m_scalar = scalar_i;
                    m_cnt    = 0;
                    m_ovf    = 1'b0;
                    foreach (m_lanes[i]) m_lanes[i] = 0;
                    if (m_n == 0) begin
                        m_wait  = 1;
                        m_phase = 2;
                    end else begin
                        m_phase = 1;
                    end
                end
                1: if (word_valid_i) begin
                    mask = (64'd1 << m_sew) - 1;
                    for (int i = 0; i < PW / m_sew; i++) begin
                        s = m_lanes[i] + ((longint'(word_i) >> (i * m_sew)) & mask);
                        if (s > mask) m_ovf = 1'b1;
                        m_lanes[i] = s & mask;
                    end
                    m_cnt++;
                    if (m_cnt == m_n) begin
                        m_wait  = fold_count(m_sew) + 1;
                        m_phase = 2;
                    end
                end
                2: begin
                    m_wait--;
                    if (m_wait == 0) begin
                        mask = (64'd1 << m_sew) - 1;
                        n = PW / m_sew;
                        while (n > 1) begin
                            h = n / 2;
                            for (int i = 0; i < h; i++) begin
                                s = m_lanes[i] + m_lanes[i + h];
                                if (s > mask) m_ovf = 1'b1;
                                m_lanes[i] = s & mask;
                            end
                            n = h;
                        end
                        s = m_lanes[0] + (longint'(m_scalar) & mask);
                        if (s > mask) m_ovf = 1'b1;
                        m_res   = 32'(s & mask);
                        m_phase = 3;
                    end
                end
                3: if (result_ready_i) m_phase = 0;
                default: m_phase = 0;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk_i) begin
        if (cmp_en) begin
            check("busy_o", busy_o, m_phase != 0);
            check("word_ready_o", word_ready_o, m_phase == 1);
            check("result_valid_o", result_valid_o, m_phase == 3);
            check("result_o", result_o, m_res);
`ifdef VCVE2_REDSUM_OVF_EN
            if (m_phase == 3) check("ovf_o", ovf_o, m_ovf);
`endif
        end
    end

    // One complete reduction using wbuf[]; entered and left just after a
    // rising edge. Returns the result, latency in cycles from start, and ovf.
    task automatic run_red(input logic [1:0] sew, input int n, input logic [31:0] scalar,
                           input bit gaps, input int hold, input bit noise,
                           output logic [31:0] res, output int lat, output bit ovf);
        int n_eff, guard, t0;
        bit rdy;
        logic [31:0] res2;
        n_eff = (n > MAXW) ? MAXW : n;
        start_i = 1'b1; sew_i = sew; num_words_i = CW'(n); scalar_i = scalar;
        @(posedge clk_i); #1;
        t0 = cyc;
        start_i = 1'b0; sew_i = 2'($urandom); num_words_i = CW'($urandom); scalar_i = $urandom;
        for (int k = 0; k < n_eff; k++) begin
            word_valid_i = 1'b1;
            word_i = wbuf[k];
            guard = 0;
            do begin
                @(negedge clk_i); rdy = word_ready_o;
                @(posedge clk_i); #1; guard++;
            end while (!rdy && guard < 50);
            if (!rdy) fail_timeout("word_accept");
            if (gaps) begin
                word_valid_i = 1'b0; word_i = $urandom;
                @(posedge clk_i); #1;
            end
        end
        word_valid_i = 1'b0;
        guard = 0;
        while (1) begin
            @(negedge clk_i);
            if (result_valid_o === 1'b1 || guard >= 100) break;
            @(posedge clk_i); #1;
            word_valid_i = noise ? 1'($urandom) : 1'b0;
            word_i = $urandom;
            guard++;
        end
        if (result_valid_o !== 1'b1) fail_timeout("result_valid");
        lat = cyc - t0 + 1;
        res = result_o;
`ifdef VCVE2_REDSUM_OVF_EN
        ovf = ovf_o;
`else
        ovf = 1'b0;
`endif
        @(posedge clk_i); #1;
        word_valid_i = 1'b0;
        for (int h = 0; h < hold; h++) begin
            start_i = (h == 0);          // must be ignored while DONE
            sew_i = 2'($urandom); num_words_i = 1;
            @(posedge clk_i); #1;
        end
        start_i = 1'b0;
        result_ready_i = 1'b1;
        @(negedge clk_i);
        res2 = result_o;
        check("held_result", res2, res);
        @(posedge clk_i); #1;
        result_ready_i = 1'b0;
    endtask

    initial begin
        logic [31:0] res;
        int lat;
        bit ovf;

        rst_i = 1'b1; start_i = 1'b0; sew_i = '0; num_words_i = '0; scalar_i = '0;
        word_valid_i = 1'b0; word_i = '0; result_ready_i = 1'b0;
        @(posedge clk_i); #1;
        cmp_en = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("reset_busy", busy_o, 0);
        check("reset_ready", word_ready_o, 0);
        check("reset_valid", result_valid_o, 0);
        check("reset_result", result_o, 0);
`ifdef VCVE2_REDSUM_OVF_EN
        check("reset_ovf", ovf_o, 0);
`endif
        @(posedge clk_i); #1;

        // SEW8 two words: lanes 11,22,33,44 -> 44,66 -> AA, + 05
        wbuf[0] = 32'h0102_0304; wbuf[1] = 32'h1020_3040;
        run_red(2'b00, 2, 32'h05, 0, 0, 0, res, lat, ovf);
        check("sew8_sum", res, 32'h0000_00AF);
        check("sew8_latency", lat, 6);       // 1 + W(2) + F(2) + 1
`ifdef VCVE2_REDSUM_OVF_EN
        check("sew8_ovf", ovf, 0);
`endif

        // SEW8 all-ones word: FE,FE -> FC, + 01, carries in fold
        wbuf[0] = 32'hFFFF_FFFF;
        run_red(2'b00, 1, 32'h01, 0, 0, 0, res, lat, ovf);
        check("sew8_wrap", res, 32'h0000_00FD);
        check("sew8_wrap_latency", lat, 5);
`ifdef VCVE2_REDSUM_OVF_EN
        check("sew8_wrap_ovf", ovf, 1);
`endif

        // SEW16: 8000+8000 wraps to 0, + 1
        wbuf[0] = 32'h8000_8000;
        run_red(2'b01, 1, 32'h0001, 0, 0, 0, res, lat, ovf);
        check("sew16_wrap", res, 32'h0000_0001);
        check("sew16_latency", lat, 4);
`ifdef VCVE2_REDSUM_OVF_EN
        check("sew16_wrap_ovf", ovf, 1);
`endif
        wbuf[0] = 32'h0001_0002;
        run_red(2'b01, 1, 32'hFFFF_1234, 0, 0, 0, res, lat, ovf);
        check("sew16_sum", res, 32'h0000_1237);

        // SEW32, zero words: scalar passes straight through
        rdy_seen = 1'b0;
        run_red(2'b10, 0, 32'hDEAD_BEEF, 0, 0, 1, res, lat, ovf);
        check("sew32_empty", res, 32'hDEAD_BEEF);
        check("sew32_empty_latency", lat, 2);
        check("sew32_empty_no_ready", rdy_seen, 0);

        // SEW8 three words with gaps, consumer stalls, start pulse in DONE:
        // lanes 34,35,36,37 -> 6A,6C -> D6, + 0A
        wbuf[0] = 32'h1111_1111; wbuf[1] = 32'h2222_2222; wbuf[2] = 32'h0102_0304;
        run_red(2'b00, 3, 32'h0A, 1, 5, 0, res, lat, ovf);
        check("sew8_gaps_sum", res, 32'h0000_00E0);
        check("after_done_idle", busy_o, 0);

        // sew=11 acts as 32; 21 words requested, clamped to 16 ones
        for (int k = 0; k < MAXW; k++) wbuf[k] = 32'h1;
        run_red(2'b11, MAXW + 5, 32'h0, 0, 0, 0, res, lat, ovf);
        check("clamp_sum", res, 32'h10);
        check("clamp_latency", lat, 18);     // 1 + 16 + 0 + 1

        // Reset after one of four words
        start_i = 1'b1; sew_i = 2'b00; num_words_i = 4; scalar_i = 32'h3;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        word_valid_i = 1'b1; word_i = 32'h0101_0101;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0; word_valid_i = 1'b0;
        @(negedge clk_i);
        check("midreset_busy", busy_o, 0);
        check("midreset_valid", result_valid_o, 0);
        check("midreset_ready", word_ready_o, 0);
        repeat (4) begin
            @(negedge clk_i);
            check("midreset_no_result", result_valid_o, 0);
        end
        @(posedge clk_i); #1;
        wbuf[0] = 32'h20;
        run_red(2'b10, 1, 32'h10, 0, 0, 0, res, lat, ovf);
        check("post_reset_sum", res, 32'h30);

        // Randomized reductions; the per-cycle compare checks against the model
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < MAXW; k++) wbuf[k] = $urandom;
            run_red(2'($urandom), $urandom_range(0, MAXW + 3), $urandom,
                    1'($urandom), $urandom_range(0, 3), 1'b1, res, lat, ovf);
            repeat ($urandom_range(0, 2)) @(posedge clk_i);
            #1;
        end

        @(negedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
